// File: rtl/trace_pkg.sv
// Shared types and constants for the commit trace path.
//   commit_entry_t : one retired instruction as seen by the harness
//   DEF_*          : default widths/depth used by commit_trace_buffer
//   ZERO_REG       : register index that never receives a writeback
package trace_pkg;

  localparam int DEF_DEPTH  = 16;
  localparam int DEF_PC_W   = 64;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_SEQ_W  = 32;
  localparam int DEF_DROP_W = 16;
  localparam int WNUM_W     = 5;

  localparam logic [WNUM_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [DEF_PC_W-1:0]   pc;
    logic [WNUM_W-1:0]     wnum;
    logic [DEF_DATA_W-1:0] wdata;
    logic [DEF_SEQ_W-1:0]  seq;
  } commit_entry_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO.
//   clock/reset : single clock, synchronous active-high reset
//   push/wdata  : write request; ignored when full unless a pop happens too
//   pop         : advance head; ignored when empty
//   rdata       : head entry while non-empty, otherwise the last popped
//                 entry (0 after reset)
//   full/empty/count : occupancy status
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] hold_q;
  logic             do_push, do_pop;

  // Extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign do_pop  = pop && !empty;
  // A pop frees the slot at the same edge, so full+pop still accepts.
  assign do_push = push && (!full || do_pop);

  // While empty the head slot is stale, so show the last popped entry.
  assign rdata = empty ? hold_q : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        hold_q <= mem[rd_ptr[AW-1:0]];
      end
    end
  end

  // Storage needs no reset; visibility is governed by the pointers.
  always_ff @(posedge clock) begin
    if (do_push && !reset) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Buffers the core's per-cycle commit stream for the difftest harness.
//   clock/reset      : single clock, synchronous active-high reset
//   in_*             : commit stream from the core debug port (never stalled)
//   out_valid/ready  : head-entry handshake to the harness
//   out_*            : head entry {pc, wnum, wdata, seq}
//   count            : FIFO occupancy
//   overflow         : sticky, a commit was dropped since reset
//   drop_cnt         : saturating count of dropped commits
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int PC_W   = DEF_PC_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEQ_W  = DEF_SEQ_W,
  parameter int DROP_W = DEF_DROP_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_commit,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [WNUM_W-1:0]      in_wnum,
  input  logic [DATA_W-1:0]      in_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic [WNUM_W-1:0]      out_wnum,
  output logic [DATA_W-1:0]      out_wdata,
  output logic [SEQ_W-1:0]       out_seq,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt
);

  localparam int ENTRY_W = PC_W + WNUM_W + DATA_W + SEQ_W;

  logic [SEQ_W-1:0]   seq_ctr;
  logic [DATA_W-1:0]  wdata_f;
  logic [ENTRY_W-1:0] push_entry, head;
  logic               fifo_full, fifo_empty, pop_ok, drop;

  // Writes to the zero register carry no data; normalise so the harness
  // never compares garbage.
  assign wdata_f    = (in_wnum == ZERO_REG) ? '0 : in_wdata;
  assign push_entry = {in_pc, in_wnum, wdata_f, seq_ctr};

  assign out_valid = !fifo_empty;
  assign pop_ok    = out_ready && !fifo_empty;
  assign drop      = in_commit && fifo_full && !pop_ok;

  assign {out_pc, out_wnum, out_wdata, out_seq} = head;

  sync_fifo_fwft #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (in_commit),
    .wdata (push_entry),
    .pop   (out_ready),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // seq advances on every commit, kept or dropped, so gaps reveal drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      seq_ctr  <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (in_commit) seq_ctr <= seq_ctr + SEQ_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench with scoreboard: stimulus queues expected entries, a
// negedge monitor checks every handshaken pop against the queue.
module tb_commit_trace_buffer;
  import trace_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_commit = 1'b0;
  logic [63:0] in_pc = '0;
  logic [4:0]  in_wnum = '0;
  logic [63:0] in_wdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [4:0]  out_wnum;
  logic [63:0] out_wdata;
  logic [31:0] out_seq;
  logic [4:0]  count;
  logic        overflow;
  logic [15:0] drop_cnt;

  int n_pass = 0;
  int n_total = 0;
  commit_entry_t sb[$];

  commit_trace_buffer dut (
    .clock(clock), .reset(reset),
    .in_commit(in_commit), .in_pc(in_pc), .in_wnum(in_wnum), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_wnum(out_wnum), .out_wdata(out_wdata), .out_seq(out_seq),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic commit(input logic [63:0] pc, input logic [4:0] wn, input logic [63:0] wd,
                        input logic [63:0] exp_wd, input logic [31:0] seq, input bit acc);
    in_commit = 1'b1; in_pc = pc; in_wnum = wn; in_wdata = wd;
    if (acc) sb.push_back('{pc: pc, wnum: wn, wdata: exp_wd, seq: seq});
    step();
    in_commit = 1'b0;
  endtask

  // Monitor: ready is driven just after posedge, so negedge sees a stable handshake.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pop: got seq %0d expected no entry", out_seq);
      end else begin
        commit_entry_t e;
        e = sb.pop_front();
        chk("pop_pc",    out_pc,    e.pc);
        chk("pop_wnum",  64'(out_wnum), 64'(e.wnum));
        chk("pop_wdata", out_wdata, e.wdata);
        chk("pop_seq",   64'(out_seq), 64'(e.seq));
      end
    end
  end

  initial begin
    // Reset then idle
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_ovf",   64'(overflow), 0);
    chk("rst_drop",  64'(drop_cnt), 0);
    chk("rst_pc",    out_pc, 0);
    chk("rst_wnum",  64'(out_wnum), 0);
    chk("rst_wdata", out_wdata, 0);
    chk("rst_seq",   64'(out_seq), 0);

    // Single commit, held until ready
    commit(64'h8000_0000, 5'd5, 64'h1234, 64'h1234, 32'd0, 1'b1);
    chk("single_valid", 64'(out_valid), 1);
    chk("single_count", 64'(count), 1);
    step(); step();
    chk("single_hold_valid", 64'(out_valid), 1);
    chk("single_hold_pc", out_pc, 64'h8000_0000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_drain_count", 64'(count), 0);
    chk("single_drain_valid", 64'(out_valid), 0);
    chk("empty_hold_pc", out_pc, 64'h8000_0000);
    chk("empty_hold_wdata", out_wdata, 64'h1234);

    // Zero-register filter, with push+pop while empty
    out_ready = 1'b1;
    commit(64'h8000_0004, 5'd0, 64'hDEAD_BEEF, 64'h0, 32'd1, 1'b1);
    chk("empty_pushpop_count", 64'(count), 1);
    step();
    out_ready = 1'b0;
    chk("zero_drain_count", 64'(count), 0);

    // Fill and overflow: seq 2..17 kept, 18..19 dropped
    for (int i = 0; i < 18; i++)
      commit(64'h9000_0000 + 64'(i*4), 5'd1, 64'h100 + 64'(i), 64'h100 + 64'(i),
             32'(2 + i), i < 16);
    chk("fill_count", 64'(count), 16);
    chk("fill_ovf",   64'(overflow), 1);
    chk("fill_drop",  64'(drop_cnt), 2);
    chk("fill_valid", 64'(out_valid), 1);

    // Full with simultaneous push and pop: seq 20..29 all accepted
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++)
      commit(64'hA000_0000 + 64'(i*4), 5'd3, 64'h200 + 64'(i), 64'h200 + 64'(i),
             32'(20 + i), 1'b1);
    chk("fullpp_count", 64'(count), 16);
    chk("fullpp_drop",  64'(drop_cnt), 2);
    for (int i = 0; i < 16; i++) step();
    out_ready = 1'b0;
    chk("drain_count", 64'(count), 0);
    chk("drain_valid", 64'(out_valid), 0);
    chk("drain_ovf_sticky", 64'(overflow), 1);

    // Mid-operation reset with a commit in the reset cycle
    for (int i = 0; i < 5; i++)
      commit(64'hB000_0000 + 64'(i*4), 5'd7, 64'h300 + 64'(i), 64'h300 + 64'(i),
             32'(30 + i), 1'b1);
    chk("pre_rst_count", 64'(count), 5);
    reset = 1'b1;
    sb.delete();
    commit(64'hBAD0, 5'd8, 64'hBAD1, 64'hBAD1, 32'd35, 1'b0);
    reset = 1'b0;
    chk("midrst_count", 64'(count), 0);
    chk("midrst_valid", 64'(out_valid), 0);
    chk("midrst_ovf",   64'(overflow), 0);
    chk("midrst_drop",  64'(drop_cnt), 0);
    chk("midrst_pc",    out_pc, 0);
    commit(64'hC000_0000, 5'd9, 64'h55, 64'h55, 32'd0, 1'b1);
    chk("post_rst_valid", 64'(out_valid), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_rst_count", 64'(count), 0);

    step();
    chk("sb_empty", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the CPU top-level debug trace port and consumes its per-cycle commit stream (commit, pc, rf_wnum, rf_wdata).
- Buffers each retired instruction in a first-word-fall-through (FWFT) FIFO and presents it to the difftest/emulator harness over a valid/ready handshake.
- The core cannot be stalled by the harness, so the block tags every commit with a sequence number and reports dropped commits rather than losing them silently.

Parameters:
DEPTH, 16, number of FIFO entries; must be a power of two, minimum 2
PC_W, 64, width of the committed PC
DATA_W, 64, width of the register-file write data
SEQ_W, 32, width of the commit sequence number
DROP_W, 16, width of the saturating dropped-commit counter

Ports:
clock  in  1  single clock for the whole block
reset  in  1  synchronous, active-high reset
in_commit  in  1  a commit occurred this cycle (from the core's debug_commit)
in_pc  in  PC_W  PC of the committed instruction
in_wnum  in  5  destination register number; 0 means no writeback
in_wdata  in  DATA_W  writeback data
out_valid  out  1  head entry is available
out_ready  in  1  harness accepts the head entry
out_pc  out  PC_W  head entry PC
out_wnum  out  5  head entry destination register
out_wdata  out  DATA_W  head entry writeback data
out_seq  out  SEQ_W  head entry sequence number
count  out  log2(DEPTH)+1  current occupancy
overflow  out  1  sticky; set when any commit has been dropped
drop_cnt  out  DROP_W  number of dropped commits, saturating

Behaviour:
- Reset: all outputs go to 0 on the first rising clock edge with reset=1. FIFO pointers, seq counter, overflow and drop_cnt are cleared. Reset asserted mid-operation flushes all entries, and any in_commit in that cycle is ignored.
- Push: when in_commit=1 and the FIFO has room, write {pc, wnum, wdata', seq} at the tail.
  - wdata' = 0 when wnum=0; otherwise wdata' = in_wdata.
- seq_ctr advances by 1 on every in_commit, whether the commit is accepted or dropped, and wraps modulo 2^SEQ_W. The first commit after reset carries seq 0. Gaps in out_seq therefore expose drops to the harness.
- Pop: a pop occurs when out_valid=1 and out_ready=1; the head advances at the next edge.
  - out_ready while empty has no effect.
- Latency: a commit presented at cycle N appears on out_* with out_valid=1 at cycle N+1 (FWFT from the storage registers). out_* are not combinationally bypassed from in_*.
- Outputs while empty: out_valid=0 and out_* hold their last value, except that they are all 0 after reset.
- Full with a simultaneous pop: the push is accepted and count is unchanged.
- Full without a pop: the commit is dropped. overflow is set (sticky until reset) and drop_cnt increments, saturating at 2^DROP_W-1. Stored entries are untouched.
- Empty with simultaneous push and pop: no pop happens (out_valid=0). The push lands, and count goes from 0 to 1.
- count: +1 on push-only, -1 on pop-only, unchanged when push and pop occur together. count never exceeds DEPTH.
- Pointers: log2(DEPTH)+1 bits wide; the extra MSB distinguishes full from empty. Wrap-around is natural modulo 2*DEPTH.
- No state machine beyond the FIFO control; all state is registered on clock.

Decomposition:
- Shared package trace_pkg:
  - struct commit_entry_t {pc, wnum, wdata, seq}
  - constants for the default DEPTH, SEQ_W and DROP_W
  - a localparam for the zero-register index
- One natural sub-module: sync_fifo_fwft (generic width/depth FWFT FIFO with push, pop, full, empty and count).
- commit_trace_buffer wraps sync_fifo_fwft and adds entry formatting, the seq counter and drop accounting.

Test Plan:
- Reset then idle: reset held 2 cycles, no commits -> out_valid=0, count=0, overflow=0, drop_cnt=0, all out_* = 0.
- Single commit: pc=0x80000000, wnum=5, wdata=0x1234 at cycle N, out_ready=0 -> at N+1 out_valid=1 with pc=0x80000000, wnum=5, wdata=0x1234, seq=0; the entry holds until out_ready=1, then count returns to 0.
- Zero-register filter: commit wnum=0, wdata=0xDEADBEEF -> out_wdata=0, wnum=0.
- Fill and overflow with DEPTH=16 and out_ready=0: 18 back-to-back commits -> count=16, overflow=1, drop_cnt=2. Draining yields seq 0..15; the next commit gets seq 18.
- Full with simultaneous push and pop: FIFO full, out_ready=1 and in_commit=1 for 10 cycles -> count stays 16, drop_cnt unchanged, popped seqs are contiguous.
- Mid-operation reset: 5 entries queued, reset pulsed for 1 cycle while in_commit=1 -> count=0, out_valid=0. The next commit carries seq 0 and overflow is cleared.
